// File: rtl/panel_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : panel_scan_pkg
//  Description : Shared types and defaults for the panel scan sequencer:
//                sequencer state encoding, acquisition mode encoding and the
//                default length of the pixel reset pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
package panel_scan_pkg;

  // Default number of clk cycles the pixel array reset pulse is held.
  localparam int RESET_CYCLES_DEFAULT = 8;

  // Sequencer states, explicit 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_INTEG     = 3'd2,
    ST_ROW_SETUP = 3'd3,
    ST_COL_SCAN  = 3'd4,
    ST_ROW_NEXT  = 3'd5,
    ST_FRAME_END = 3'd6
  } state_e;

  // Acquisition modes as presented on the mode input. The reserved code
  // behaves like SINGLE because only MULTI repeats and only DARK skips
  // integration.
  typedef enum logic [1:0] {
    MODE_SINGLE = 2'd0,
    MODE_MULTI  = 2'd1,
    MODE_DARK   = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

endpackage : panel_scan_pkg
`default_nettype wire

// File: rtl/panel_scan_sequencer_addr_counter.sv
`default_nettype none
// ============================================================================
//  Module      : scan_addr_counter
//  Description : Loadable address stepper for one scan axis (row or column).
//                The address is loaded with start_addr, advanced by step on
//                request, and 'last' flags that the next step would pass
//                end_addr. The next-address sum is formed one bit wider than
//                the address so an end of all-ones cannot wrap to zero.
//  Ports       : clk, rst         - clock, synchronous active-high reset
//                start_addr       - address loaded on 'load'
//                end_addr         - inclusive last legal address
//                step             - increment (ADDR_W+1 bits)
//                load, advance    - load has priority over advance
//                addr             - current address (registered)
//                last             - current address is the final one
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_addr_counter #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [ADDR_W:0]   step,
  input  logic              load,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W:0]   next_addr;

  always_comb begin
    next_addr = {1'b0, addr_q} + step;
    last      = (next_addr > {1'b0, end_addr});
    addr_d    = addr_q;
    if (load) begin
      addr_d = start_addr;
    end else if (advance && !last) begin
      addr_d = next_addr[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;

endmodule : scan_addr_counter
`default_nettype wire

// File: rtl/panel_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : panel_scan_sequencer
//  Description : Frame acquisition sequencer for a pixel panel. On an
//                accepted frame_start it latches the configuration, pulses
//                the pixel reset, waits the integration time, then walks the
//                region of interest row by row, handing each pixel to the
//                ADC with an adc_start / adc_ready handshake. MULTI mode
//                repeats the frame frame_count times.
//  Config      : PANEL_SCAN_BINNING_EN - when defined, rows and columns step
//                by 1<<bin_shift; otherwise bin_shift is ignored (step 1).
//  Ports       : clk, rst                  - clock, sync active-high reset
//                frame_start, frame_abort  - start / abort pulses
//                mode, frame_count         - acquisition mode, MULTI count
//                integration_time          - integration in ticks
//                bin_shift                 - binning step exponent
//                row_start/end, col_start/end - inclusive ROI
//                adc_ready                 - ADC accepted current pixel
//                frame_busy, frame_complete, acq_done, roi_err - status
//                row_addr, col_addr        - current pixel address
//                row_clk_en, col_clk_en, gate_sel, reset_pulse, adc_start
//                                          - panel / ADC strobes
//                frames_done               - frames completed this run
//  Revision    : 1.0 - initial release
// ============================================================================
module panel_scan_sequencer
  import panel_scan_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int INTEG_W      = 16,
  parameter int TICK_DIV     = 100,
  parameter int RESET_CYCLES = RESET_CYCLES_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               frame_abort,
  input  logic [1:0]         mode,
  input  logic [7:0]         frame_count,
  input  logic [INTEG_W-1:0] integration_time,
  input  logic [1:0]         bin_shift,
  input  logic [ADDR_W-1:0]  row_start,
  input  logic [ADDR_W-1:0]  row_end,
  input  logic [ADDR_W-1:0]  col_start,
  input  logic [ADDR_W-1:0]  col_end,
  input  logic               adc_ready,
  output logic               frame_busy,
  output logic               frame_complete,
  output logic               acq_done,
  output logic               roi_err,
  output logic [ADDR_W-1:0]  row_addr,
  output logic [ADDR_W-1:0]  col_addr,
  output logic               row_clk_en,
  output logic               col_clk_en,
  output logic               gate_sel,
  output logic               reset_pulse,
  output logic               adc_start,
  output logic [7:0]         frames_done
);

  // One shared cycle counter serves both the reset pulse and the tick divider.
  localparam int CNT_W = $clog2(RESET_CYCLES + TICK_DIV + 1);

`ifdef PANEL_SCAN_BINNING_EN
  localparam logic [1:0] BIN_MASK = 2'b11;
`else
  // A zero mask collapses the shift amount so the step is always 1.
  localparam logic [1:0] BIN_MASK = 2'b00;
`endif

  // --------------------------------------------------------------------------
  // State and latched configuration
  // --------------------------------------------------------------------------
  state_e              state_q,       state_d;
  logic [CNT_W-1:0]    cnt_q,         cnt_d;
  logic [INTEG_W-1:0]  tick_q,        tick_d;
  logic [7:0]          frames_done_q, frames_done_d;
  logic                acq_done_q,    acq_done_d;
  logic                roi_err_q,     roi_err_d;

  mode_e               mode_q,        mode_d;
  logic [7:0]          fcount_q,      fcount_d;
  logic [INTEG_W-1:0]  integ_q,       integ_d;
  logic [1:0]          bin_shift_q,   bin_shift_d;
  logic [ADDR_W-1:0]   row_start_q,   row_start_d;
  logic [ADDR_W-1:0]   row_end_q,     row_end_d;
  logic [ADDR_W-1:0]   col_start_q,   col_start_d;
  logic [ADDR_W-1:0]   col_end_q,     col_end_d;

  // Address counter control
  logic                row_load, row_adv, row_last;
  logic                col_load, col_adv, col_last;
  logic [ADDR_W:0]     step;

  // Helpers
  logic [7:0]          frames_inc;
  logic [7:0]          fcount_eff;
  logic                roi_bad;
  logic                aborting;

  assign step       = {{ADDR_W{1'b0}}, 1'b1} << (bin_shift_q & BIN_MASK);
  assign frames_inc = (frames_done_q == 8'hFF) ? 8'hFF : frames_done_q + 8'd1;
  assign fcount_eff = (fcount_q == 8'd0) ? 8'd1 : fcount_q;
  assign roi_bad    = (row_start > row_end) || (col_start > col_end);
  assign aborting   = frame_abort && (state_q != ST_IDLE);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tick_d        = tick_q;
    frames_done_d = frames_done_q;
    acq_done_d    = 1'b0;
    roi_err_d     = 1'b0;
    mode_d        = mode_q;
    fcount_d      = fcount_q;
    integ_d       = integ_q;
    bin_shift_d   = bin_shift_q;
    row_start_d   = row_start_q;
    row_end_d     = row_end_q;
    col_start_d   = col_start_q;
    col_end_d     = col_end_q;
    row_load      = 1'b0;
    row_adv       = 1'b0;
    col_load      = 1'b0;
    col_adv       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          if (roi_bad) begin
            roi_err_d = 1'b1;
          end else begin
            mode_d        = mode_e'(mode);
            fcount_d      = frame_count;
            integ_d       = integration_time;
            bin_shift_d   = bin_shift;
            row_start_d   = row_start;
            row_end_d     = row_end;
            col_start_d   = col_start;
            col_end_d     = col_end;
            frames_done_d = 8'd0;
            cnt_d         = '0;
            state_d       = ST_RESET;
          end
        end
      end

      ST_RESET: begin
        // Row address is parked on the first ROI row while the array resets.
        row_load = 1'b1;
        if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
          cnt_d  = '0;
          tick_d = '0;
          if ((mode_q == MODE_DARK) || (integ_q == '0)) begin
            state_d = ST_ROW_SETUP;
          end else begin
            state_d = ST_INTEG;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_INTEG: begin
        if (cnt_q == CNT_W'(TICK_DIV - 1)) begin
          cnt_d = '0;
          if (tick_q == integ_q - INTEG_W'(1)) begin
            state_d = ST_ROW_SETUP;
          end else begin
            tick_d = tick_q + INTEG_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_ROW_SETUP: begin
        col_load = 1'b1;
        state_d  = ST_COL_SCAN;
      end

      ST_COL_SCAN: begin
        if (adc_ready) begin
          if (col_last) begin
            state_d = ST_ROW_NEXT;
          end else begin
            col_adv = 1'b1;
          end
        end
      end

      ST_ROW_NEXT: begin
        if (row_last) begin
          state_d = ST_FRAME_END;
        end else begin
          row_adv = 1'b1;
          state_d = ST_ROW_SETUP;
        end
      end

      ST_FRAME_END: begin
        frames_done_d = frames_inc;
        // Compare against the post-increment count: this frame is now done.
        if ((mode_q == MODE_MULTI) && (frames_inc < fcount_eff)) begin
          cnt_d   = '0;
          state_d = ST_RESET;
        end else begin
          acq_done_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides whatever the state wanted to do this cycle.
    if (aborting) begin
      state_d       = ST_IDLE;
      frames_done_d = frames_done_q;
      acq_done_d    = 1'b0;
      row_adv       = 1'b0;
      col_adv       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      tick_q        <= '0;
      frames_done_q <= 8'd0;
      acq_done_q    <= 1'b0;
      roi_err_q     <= 1'b0;
      mode_q        <= MODE_SINGLE;
      fcount_q      <= 8'd0;
      integ_q       <= '0;
      bin_shift_q   <= 2'd0;
      row_start_q   <= '0;
      row_end_q     <= '0;
      col_start_q   <= '0;
      col_end_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tick_q        <= tick_d;
      frames_done_q <= frames_done_d;
      acq_done_q    <= acq_done_d;
      roi_err_q     <= roi_err_d;
      mode_q        <= mode_d;
      fcount_q      <= fcount_d;
      integ_q       <= integ_d;
      bin_shift_q   <= bin_shift_d;
      row_start_q   <= row_start_d;
      row_end_q     <= row_end_d;
      col_start_q   <= col_start_d;
      col_end_q     <= col_end_d;
    end
  end

  // --------------------------------------------------------------------------
  // Address steppers
  // --------------------------------------------------------------------------
  scan_addr_counter #(
    .ADDR_W (ADDR_W)
  ) u_row_cnt (
    .clk        (clk),
    .rst        (rst),
    .start_addr (row_start_q),
    .end_addr   (row_end_q),
    .step       (step),
    .load       (row_load),
    .advance    (row_adv),
    .addr       (row_addr),
    .last       (row_last)
  );

  scan_addr_counter #(
    .ADDR_W (ADDR_W)
  ) u_col_cnt (
    .clk        (clk),
    .rst        (rst),
    .start_addr (col_start_q),
    .end_addr   (col_end_q),
    .step       (step),
    .load       (col_load),
    .advance    (col_adv),
    .addr       (col_addr),
    .last       (col_last)
  );

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign frame_busy     = (state_q != ST_IDLE);
  assign reset_pulse    = (state_q == ST_RESET);
  assign row_clk_en     = (state_q == ST_ROW_SETUP);
  assign gate_sel       = (state_q == ST_ROW_SETUP);
  assign adc_start      = (state_q == ST_COL_SCAN);
  // The two handshake-style pulses are suppressed by a same-cycle abort.
  assign col_clk_en     = (state_q == ST_COL_SCAN) && adc_ready && !frame_abort;
  assign frame_complete = (state_q == ST_FRAME_END) && !frame_abort;
  assign acq_done       = acq_done_q;
  assign roi_err        = roi_err_q;
  assign frames_done    = frames_done_q;

endmodule : panel_scan_sequencer
`default_nettype wire

// File: doc/panel_scan_sequencer.md
PANEL_SCAN_SEQUENCER -- requirements
Module: panel_scan_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning row/col address width.
REQ-002 SHALL have parameter INTEG_W, default 16, meaning integration_time width.
REQ-003 SHALL have parameter TICK_DIV, default 100, meaning clk cycles per integration tick.
REQ-004 SHALL have parameter RESET_CYCLES, default 8, meaning reset_pulse length in clk cycles.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port frame_start, input, 1, a one-cycle pulse that starts acquisition.
REQ-008 SHALL have port frame_abort, input, 1, a pulse that aborts the current acquisition.
REQ-009 SHALL have port mode, input, 2: 0 = SINGLE, 1 = MULTI, 2 = DARK (no integration), 3 = reserved, treated as SINGLE.
REQ-010 SHALL have port frame_count, input, 8, the number of frames in MULTI mode (0 treated as 1).
REQ-011 SHALL have port integration_time, input, INTEG_W, the integration time in ticks.
REQ-012 SHALL have port bin_shift, input, 2, giving a row/col step of 1<<bin_shift.
REQ-013 SHALL have ports row_start, row_end, col_start, col_end, input, ADDR_W each, the inclusive ROI.
REQ-014 SHALL have port adc_ready, input, 1, the ADC acceptance handshake.
REQ-015 SHALL have outputs frame_busy (1), frame_complete (1), acq_done (1), roi_err (1).
REQ-016 SHALL have outputs row_addr and col_addr, each ADDR_W.
REQ-017 SHALL have outputs row_clk_en, col_clk_en, gate_sel, reset_pulse and adc_start, 1 bit each.
REQ-018 SHALL have output frames_done, 8 bits.

Function
REQ-019 SHALL implement states IDLE -> RESET -> INTEG -> ROW_SETUP -> COL_SCAN -> ROW_NEXT -> FRAME_END -> (RESET or IDLE).
REQ-020 SHALL latch all configuration inputs on frame_start in IDLE; input changes mid-acquisition SHALL have no effect.
REQ-021 SHALL, on frame_start with row_start>row_end or col_start>col_end, stay in IDLE and pulse roi_err for 1 cycle.
REQ-022 SHALL ignore frame_start whenever the state is not IDLE.
REQ-023 SHALL assert reset_pulse for exactly RESET_CYCLES cycles in RESET.
REQ-024 SHALL stay in INTEG for integration_time*TICK_DIV cycles; zero time or DARK mode SHALL skip INTEG in 0 cycles.
REQ-025 SHALL, in ROW_SETUP, drive row_addr to the current row, gate_sel=1 and row_clk_en=1 for 1 cycle.
REQ-026 SHALL, in COL_SCAN, hold adc_start=1 with a stable col_addr until the adc_ready cycle, then pulse col_clk_en and step the column.
REQ-027 SHALL advance row and column by 1<<bin_shift and leave the row or column when the next address would exceed its end; no address SHALL exceed row_end or col_end.
REQ-028 SHALL compute address stepping at ADDR_W+1 bits so that an end value of 2^ADDR_W-1 does not wrap to 0.
REQ-029 SHALL, in FRAME_END, pulse frame_complete for 1 cycle and increment frames_done (saturating at 255).
REQ-030 SHALL return to RESET from FRAME_END in MULTI mode while frames_done < frame_count; otherwise it SHALL go to IDLE and pulse acq_done.
REQ-031 SHALL hold frame_busy=1 in every state except IDLE.
REQ-032 SHALL, on frame_abort in any non-IDLE state, go to IDLE next cycle, deassert all strobes, pulse neither frame_complete nor acq_done, and preserve frames_done.
REQ-033 SHALL give frame_abort priority over adc_ready and over every state transition in the same cycle.
REQ-034 SHALL clear frames_done to 0 on each accepted frame_start.

Reset
REQ-035 SHALL, while rst=1, force IDLE with all outputs at 0: addresses 0, frames_done 0, all strobes and flags 0.
REQ-036 SHALL treat rst mid-acquisition identically to REQ-035, producing no completion pulses.

Configuration
REQ-037 SHALL honour bin_shift in stepping only when PANEL_SCAN_BINNING_EN is defined.
REQ-038 SHALL, when PANEL_SCAN_BINNING_EN is undefined, ignore bin_shift and use a step of 1.

Structure
REQ-039 SHALL place the state enum, the mode enum and the RESET_CYCLES default in package panel_scan_pkg.
REQ-040 SHALL implement row and column stepping with two instances of sub-module scan_addr_counter (start, end, step, load, advance, last flag).

Verification
REQ-041 SHALL test SINGLE, ROI 0-1/0-1, integration_time 0, adc_ready tied 1 -> addresses (0,0),(0,1),(1,0),(1,1), one frame_complete, one acq_done.
REQ-042 SHALL test MULTI with frame_count 3, integration_time 2, TICK_DIV 4 -> 8-cycle INTEG per frame, three frame_complete pulses, frames_done=3, one acq_done.
REQ-043 SHALL test adc_ready held low for 5 cycles at (0,1) -> adc_start high and col_addr=1 stable for those 5 cycles.
REQ-044 SHALL test binning with bin_shift 1, ROI rows 0-4 and cols 0-3, macro defined -> rows 0,2,4 and cols 0,2; macro undefined -> all 5x4 addresses.
REQ-045 SHALL test frame_abort during COL_SCAN of frame 2 of 3 -> IDLE next cycle, frame_busy=0, frames_done=1, no acq_done.
REQ-046 SHALL test row_start=5, row_end=2 -> state stays IDLE, one roi_err pulse; also ROI cols 4094-4095 with ADDR_W=12 -> no wrap.
